// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : writeback_arbiter_if                                        |
// | Description : Bundle of ALU, long-latency, write-port and probe signals   |
// |               exchanged with the write-back arbiter.                      |
// | Revision    : 1.0                                                         |
// +----------------------------------------------------------------------------+
interface writeback_arbiter_if #(
  parameter int REGISTER_WIDTH = 32,
  parameter int FIFO_DEPTH     = 4
);
  // ALU result stream
  logic                          alu_valid;
  logic [4:0]                    alu_addr;
  logic [REGISTER_WIDTH-1:0]     alu_data;
  logic                          alu_is_float;
  logic                          alu_stall;
  // Long-latency result stream
  logic                          lu_valid;
  logic                          lu_ready;
  logic [4:0]                    lu_addr;
  logic [REGISTER_WIDTH-1:0]     lu_data;
  logic                          lu_is_float;
  // Register-file write port
  logic                          register_to_write_en;
  logic [4:0]                    register_to_write_addr;
  logic [REGISTER_WIDTH-1:0]     register_to_write_data;
  logic                          isFloat;
  // Hazard probe and occupancy
  logic [4:0]                    probe_addr;
  logic                          probe_is_float;
  logic                          probe_pending;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  // Producer / issue side
  modport master (
    output alu_valid, alu_addr, alu_data, alu_is_float,
    input  alu_stall,
    output lu_valid, lu_addr, lu_data, lu_is_float,
    input  lu_ready,
    input  register_to_write_en, register_to_write_addr, register_to_write_data, isFloat,
    output probe_addr, probe_is_float,
    input  probe_pending, fifo_count
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_addr, alu_data, alu_is_float,
    output alu_stall,
    input  lu_valid, lu_addr, lu_data, lu_is_float,
    output lu_ready,
    output register_to_write_en, register_to_write_addr, register_to_write_data, isFloat,
    input  probe_addr, probe_is_float,
    output probe_pending, fifo_count
  );
endinterface
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : writeback_arbiter                                           |
// | Description : Merges the ALU stream with FIFO-buffered long-latency       |
// |               results onto one registered register-file write port, with  |
// |               starvation forcing and a pending-write hazard probe.        |
// | Revision    : 1.0                                                         |
// +----------------------------------------------------------------------------+
module writeback_arbiter #(
  parameter int REGISTER_WIDTH = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                clk,
  input  logic                resetn,
  writeback_arbiter_if.slave  bus
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);

  // FIFO storage (contents are meaningless outside the occupied window)
  logic [4:0]                fifo_addr_q  [FIFO_DEPTH];
  logic [REGISTER_WIDTH-1:0] fifo_data_q  [FIFO_DEPTH];
  logic                      fifo_float_q [FIFO_DEPTH];

  logic [c_PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [c_PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [c_CNT_W-1:0]        count_q, count_d;
  logic [c_STV_W-1:0]        starve_q, starve_d;

  logic                      wr_en_q, wr_en_d;
  logic [4:0]                wr_addr_q, wr_addr_d;
  logic [REGISTER_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                      wr_float_q, wr_float_d;

  logic w_empty, w_force, w_pop, w_alu_win, w_lu_ready, w_push, w_probe_hit;

  // Grant decision and FIFO handshake
  always_comb begin
    w_empty    = (count_q == '0);
    w_force    = (starve_q == c_STV_W'(STARVE_LIMIT)) && !w_empty;
    w_pop      = w_force || (!bus.alu_valid && !w_empty);
    w_alu_win  = bus.alu_valid && !w_force;
    w_lu_ready = (count_q != c_CNT_W'(FIFO_DEPTH));
    // integer x0 results complete the handshake but are discarded
    w_push     = bus.lu_valid && w_lu_ready && !(!bus.lu_is_float && bus.lu_addr == 5'd0);
  end

  // Next state for the write port, pointers, occupancy and starve counter
  always_comb begin
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_float_d = wr_float_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    starve_d   = starve_q;

    if (w_pop) begin
      wr_en_d    = 1'b1;
      wr_addr_d  = fifo_addr_q[rd_ptr_q];
      wr_data_d  = fifo_data_q[rd_ptr_q];
      wr_float_d = fifo_float_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + 1'b1;
    end else if (w_alu_win) begin
      wr_en_d    = !(!bus.alu_is_float && bus.alu_addr == 5'd0);
      wr_addr_d  = bus.alu_addr;
      wr_data_d  = bus.alu_data;
      wr_float_d = bus.alu_is_float;
    end

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (w_pop || w_empty) begin
      starve_d = '0;
    end else if (w_alu_win && starve_q != c_STV_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // State registers; reset drops every queued entry at once
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_float_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_float_q <= wr_float_d;
    end
  end

  // FIFO payload write at the tail
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_addr_q[wr_ptr_q]  <= bus.lu_addr;
      fifo_data_q[wr_ptr_q]  <= bus.lu_data;
      fifo_float_q[wr_ptr_q] <= bus.lu_is_float;
    end
  end

  // Hazard probe over occupied FIFO slots and the live output register
  always_comb begin
    logic [c_PTR_W-1:0] w_offset;
    w_probe_hit = 1'b0;
    w_offset    = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_offset = c_PTR_W'(i) - rd_ptr_q;
      if ({1'b0, w_offset} < count_q &&
          fifo_addr_q[i] == bus.probe_addr &&
          fifo_float_q[i] == bus.probe_is_float) begin
        w_probe_hit = 1'b1;
      end
    end
    if (wr_en_q && wr_addr_q == bus.probe_addr && wr_float_q == bus.probe_is_float) begin
      w_probe_hit = 1'b1;
    end
    if (!bus.probe_is_float && bus.probe_addr == 5'd0) begin
      w_probe_hit = 1'b0;
    end
  end

  assign bus.alu_stall              = bus.alu_valid && w_force;
  assign bus.lu_ready               = w_lu_ready;
  assign bus.register_to_write_en   = wr_en_q;
  assign bus.register_to_write_addr = wr_addr_q;
  assign bus.register_to_write_data = wr_data_q;
  assign bus.isFloat                = wr_float_q;
  assign bus.probe_pending          = w_probe_hit;
  assign bus.fifo_count             = count_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_writeback_arbiter                                        |
// | Description : Self-checking bench for writeback_arbiter: directed table,  |
// |               multi-cycle corner sequences and randomized traffic checked |
// |               against a queue-based reference model.                      |
// | Revision    : 1.0                                                         |
// +----------------------------------------------------------------------------+
module tb_writeback_arbiter;
  localparam int c_W     = 32;
  localparam int c_DEPTH = 4;
  localparam int c_LIMIT = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  writeback_arbiter_if #(.REGISTER_WIDTH(c_W), .FIFO_DEPTH(c_DEPTH)) bus ();

  writeback_arbiter #(.REGISTER_WIDTH(c_W), .FIFO_DEPTH(c_DEPTH), .STARVE_LIMIT(c_LIMIT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]     a;
    logic [c_W-1:0] d;
    logic           f;
  } ent_t;

  ent_t           mq[$];
  int             m_starve;
  logic           m_en;
  logic [4:0]     m_addr;
  logic [c_W-1:0] m_data;
  logic           m_flt;
  bit             m_hold_unk;  // after an x0 ALU grant the held addr/data are not pinned down
  bit             m_stall_now;

  function automatic void model_reset();
    mq.delete();
    m_starve = 0; m_en = 0; m_addr = '0; m_data = '0; m_flt = 0; m_hold_unk = 0;
  endfunction

  function automatic bit model_force();
    return (m_starve == c_LIMIT) && (mq.size() != 0);
  endfunction

  function automatic bit model_probe();
    if (!bus.probe_is_float && bus.probe_addr == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].a == bus.probe_addr && mq[i].f == bus.probe_is_float) return 1'b1;
    if (m_en && m_addr == bus.probe_addr && m_flt == bus.probe_is_float) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of the rules: pick winner, update starvation, then enqueue
  function automatic void model_step();
    bit   was_empty = (mq.size() == 0);
    bit   room      = (mq.size() != c_DEPTH);
    bit   frc       = model_force();
    ent_t e;
    if (frc || (!bus.alu_valid && !was_empty)) begin
      e = mq.pop_front();
      m_en = 1; m_addr = e.a; m_data = e.d; m_flt = e.f; m_hold_unk = 0;
      m_starve = 0;
    end else if (bus.alu_valid) begin
      m_en = !(bus.alu_addr == 5'd0 && !bus.alu_is_float);
      m_addr = bus.alu_addr; m_data = bus.alu_data; m_flt = bus.alu_is_float;
      m_hold_unk = !m_en;
      m_starve = was_empty ? 0 : ((m_starve + 1 > c_LIMIT) ? c_LIMIT : m_starve + 1);
    end else begin
      m_en = 0;
      m_starve = 0;
    end
    if (bus.lu_valid && room && !(bus.lu_addr == 5'd0 && !bus.lu_is_float)) begin
      e.a = bus.lu_addr; e.d = bus.lu_data; e.f = bus.lu_is_float;
      mq.push_back(e);
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("en", bus.register_to_write_en, m_en);
    if (!m_hold_unk) begin
      chk("addr", bus.register_to_write_addr, m_addr);
      chk("data", bus.register_to_write_data, m_data);
      chk("isFloat", bus.isFloat, m_flt);
    end
    chk("count", bus.fifo_count, mq.size());
    chk("lu_ready", bus.lu_ready, mq.size() != c_DEPTH);
    chk("alu_stall", bus.alu_stall, bus.alu_valid && model_force());
    chk("probe", bus.probe_pending, model_probe());
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad, input logic af,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld, input logic lf);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad; bus.alu_is_float = af;
    bus.lu_valid = lv; bus.lu_addr = la; bus.lu_data = ld; bus.lu_is_float = lf;
  endtask

  // Check mid-cycle, then advance model and DUT together; returns at posedge+1
  task automatic cycle();
    @(negedge clk);
    check_model();
    m_stall_now = bus.alu_valid && model_force();
    @(posedge clk);
    if (resetn) model_step();
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    bus.probe_addr = 0; bus.probe_is_float = 0;
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic           av; logic [4:0] aa; logic [31:0] ad; logic af;
    logic           lv; logic [4:0] la; logic [31:0] ld; logic lf;
    logic           x_stall; logic x_ready; logic x_en;
    logic [4:0]     x_addr; logic [31:0] x_data; logic x_flt; logic [2:0] x_cnt; logic chk_d;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int   alu_n, lu_n, exp_next, writes, held_addr;
    bit   stall_now, ready_now;

    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   alu_n, lu_n, exp_next, writes;
    logic [4:0] held_addr;
    bit   stall_now, ready_now;

    //          av aa ad        af lv la ld        lf  st rd en addr data      f  cnt chk
    tbl[0]  = '{0, 0, 0,        0, 0, 0, 0,        0,  0, 1, 0, 0, 32'h0,    0, 0, 1};
    tbl[1]  = '{1, 5, 32'h1234, 0, 0, 0, 0,        0,  0, 1, 1, 5, 32'h1234, 0, 0, 1};
    tbl[2]  = '{1, 0, 32'h77,   0, 0, 0, 0,        0,  0, 1, 0, 0, 32'h0,    0, 0, 0};
    tbl[3]  = '{0, 0, 0,        0, 1, 1, 32'h100,  1,  0, 1, 0, 0, 32'h0,    0, 1, 0};
    tbl[4]  = '{0, 0, 0,        0, 1, 2, 32'h200,  1,  0, 1, 1, 1, 32'h100,  1, 1, 1};
    tbl[5]  = '{0, 0, 0,        0, 1, 3, 32'h300,  1,  0, 1, 1, 2, 32'h200,  1, 1, 1};
    tbl[6]  = '{0, 0, 0,        0, 1, 4, 32'h400,  1,  0, 1, 1, 3, 32'h300,  1, 1, 1};
    tbl[7]  = '{0, 0, 0,        0, 0, 0, 0,        0,  0, 1, 1, 4, 32'h400,  1, 0, 1};
    tbl[8]  = '{0, 0, 0,        0, 0, 0, 0,        0,  0, 1, 0, 4, 32'h400,  1, 0, 1};
    tbl[9]  = '{0, 0, 0,        0, 1, 0, 32'h999,  0,  0, 1, 0, 4, 32'h400,  1, 0, 1};
    tbl[10] = '{1, 0, 32'h55,   1, 0, 0, 0,        0,  0, 1, 1, 0, 32'h55,   1, 0, 1};

    // Reset and idle
    do_reset();
    repeat (3) cycle();
    chk("reset_en", bus.register_to_write_en, 0);
    chk("reset_ready", bus.lu_ready, 1);
    chk("reset_count", bus.fifo_count, 0);
    chk("reset_probe", bus.probe_pending, 0);

    // Directed table: comb outputs before the edge, registered outputs after it
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].af, tbl[i].lv, tbl[i].la, tbl[i].ld, tbl[i].lf);
      @(negedge clk);
      chk($sformatf("tbl%0d_stall", i), bus.alu_stall, tbl[i].x_stall);
      chk($sformatf("tbl%0d_ready", i), bus.lu_ready, tbl[i].x_ready);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_en", i), bus.register_to_write_en, tbl[i].x_en);
      chk($sformatf("tbl%0d_cnt", i), bus.fifo_count, tbl[i].x_cnt);
      if (tbl[i].chk_d) begin
        chk($sformatf("tbl%0d_addr", i), bus.register_to_write_addr, tbl[i].x_addr);
        chk($sformatf("tbl%0d_data", i), bus.register_to_write_data, tbl[i].x_data);
        chk($sformatf("tbl%0d_flt", i), bus.isFloat, tbl[i].x_flt);
      end
    end

    // Starvation: ALU always valid, five LU offers; forced pops at iterations 9 and 18
    do_reset();
    alu_n = 0; lu_n = 0; held_addr = 0;
    for (int it = 0; it < 20; it++) begin
      drive(1, 5'(10 + alu_n % 16), 32'hA000 + 32'(alu_n), 0,
            lu_n < 5, 5'(lu_n + 1), 32'hB000 + 32'(lu_n), 0);
      @(negedge clk);
      check_model();
      chk($sformatf("starve_stall_it%0d", it), bus.alu_stall, (it == 9 || it == 18));
      if (it <= 10) chk($sformatf("full_ready_it%0d", it), bus.lu_ready, !(it >= 4 && it <= 9));
      stall_now = bus.alu_valid && model_force();
      ready_now = (mq.size() != c_DEPTH);
      held_addr = bus.alu_addr;
      @(posedge clk);
      model_step();
      #1;
      if (ready_now && lu_n < 5) lu_n++;
      if (!stall_now) alu_n++;
      if (it == 9)  chk("forced_pop_addr1", bus.register_to_write_addr, 1);
      if (it == 10) chk("held_alu_written", bus.register_to_write_addr, held_addr);
      if (it == 18) chk("forced_pop_addr2", bus.register_to_write_addr, 2);
    end

    // Simultaneous push and pop at occupancy 2
    do_reset();
    drive(1, 11, 32'h11, 0, 1, 1, 32'hC1, 0); cycle();
    drive(1, 12, 32'h12, 0, 1, 2, 32'hC2, 0); cycle();
    chk("pre_pushpop_cnt", bus.fifo_count, 2);
    drive(0, 0, 0, 0, 1, 3, 32'hC3, 0); cycle();
    chk("pushpop_cnt", bus.fifo_count, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) cycle();

    // Pointer wrap: 12 pushes drain in order with data intact
    do_reset();
    exp_next = 1; writes = 0;
    for (int k = 0; k < 20; k++) begin
      if (k < 12) drive(0, 0, 0, 0, 1, 5'(k + 1), 32'h1111 * 32'(k + 1), 1);
      else        drive(0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      if (bus.register_to_write_en) begin
        chk("wrap_addr", bus.register_to_write_addr, exp_next);
        chk("wrap_data", bus.register_to_write_data, 32'h1111 * 32'(exp_next));
        exp_next++; writes++;
      end
    end
    chk("wrap_writes", writes, 12);

    // Asynchronous reset with three queued float entries
    do_reset();
    drive(1, 12, 32'h1, 0, 1, 7, 32'h70, 1); cycle();
    drive(1, 12, 32'h1, 0, 1, 8, 32'h80, 1); cycle();
    drive(1, 12, 32'h1, 0, 1, 9, 32'h90, 1); cycle();
    drive(1, 12, 32'h1, 0, 0, 0, 0, 0);
    bus.probe_addr = 8; bus.probe_is_float = 1;
    #1;
    chk("prereset_probe", bus.probe_pending, 1);
    chk("prereset_count", bus.fifo_count, 3);
    #2 resetn = 1'b0;
    #1;
    chk("rst_en", bus.register_to_write_en, 0);
    chk("rst_addr", bus.register_to_write_addr, 0);
    chk("rst_data", bus.register_to_write_data, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_ready", bus.lu_ready, 1);
    chk("rst_probe", bus.probe_pending, 0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 resetn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("postrst_no_write", bus.register_to_write_en, 0);
    end

    // Randomized traffic against the model; stalled ALU inputs are held
    do_reset();
    m_stall_now = 0;
    for (int k = 0; k < 400; k++) begin
      if (!m_stall_now) begin
        bus.alu_valid    = ($urandom_range(0, 2) != 0);
        bus.alu_addr     = 5'($urandom_range(0, 7));
        bus.alu_data     = $urandom;
        bus.alu_is_float = 1'($urandom_range(0, 1));
      end
      bus.lu_valid       = 1'($urandom_range(0, 1));
      bus.lu_addr        = 5'($urandom_range(0, 7));
      bus.lu_data        = $urandom;
      bus.lu_is_float    = 1'($urandom_range(0, 1));
      bus.probe_addr     = 5'($urandom_range(0, 7));
      bus.probe_is_float = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire
